// File: rtl/bus_arbiter.sv
// Round-robin arbiter moving one packet per two cycles from device transmit FIFOs to receive FIFOs.
// Optional macro BUS_ARBITER_BROADCAST_EN: destination BROADCAST pushes every device except the sender.
module bus_arbiter #(
  parameter int         DEVICES   = 4,
  parameter int         WIDTH     = 16,
  parameter logic [7:0] BROADCAST = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DEVICES-1:0]         pndng,
  input  logic [DEVICES*WIDTH-1:0]   d_pop,
  output logic [DEVICES-1:0]         pop,
  output logic [WIDTH-1:0]           d_push,
  output logic [DEVICES-1:0]         push,
  output logic [7:0]                 drop_cnt
);

  localparam int GW = $clog2(DEVICES);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic [GW-1:0]      last_grant_q, last_grant_d;
  logic [GW-1:0]      rr_grant, rr_idx;
  logic               rr_found;
  logic [WIDTH-1:0]   word_q, word_d;
  logic [WIDTH-1:0]   d_push_q, d_push_d;
  logic [DEVICES-1:0] pop_q, pop_d;
  logic [DEVICES-1:0] push_q, push_d;
  logic [7:0]         drop_q, drop_d;
  logic [7:0]         dest;
  logic [DEVICES-1:0] grant_onehot, unicast_mask, dest_mask;
  logic [WIDTH-1:0]   src_word [DEVICES];

  // While in SEND, last_grant_q is the device whose word is held in word_q.
  assign dest = word_q[WIDTH-1 -: 8];

  genvar gi;
  generate
    for (gi = 0; gi < DEVICES; gi++) begin : g_dev
      assign src_word[gi]     = d_pop[gi*WIDTH +: WIDTH];
      assign grant_onehot[gi] = (last_grant_q == GW'(gi));
      assign unicast_mask[gi] = (dest == 8'(gi)) && !grant_onehot[gi];
    end
  endgenerate

  // Circular search starting one past the previous winner.
  always_comb begin
    rr_grant = last_grant_q;
    rr_idx   = last_grant_q;
    rr_found = 1'b0;
    for (int k = 1; k <= DEVICES; k++) begin
      rr_idx = GW'((int'(last_grant_q) + k) % DEVICES);
      if (!rr_found && pndng[rr_idx]) begin
        rr_found = 1'b1;
        rr_grant = rr_idx;
      end
    end
  end

  always_comb begin
`ifdef BUS_ARBITER_BROADCAST_EN
    if (dest == BROADCAST) dest_mask = ~grant_onehot;
    else                   dest_mask = unicast_mask;
`else
    if (dest == BROADCAST) dest_mask = '0;
    else                   dest_mask = unicast_mask;
`endif
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    word_d       = word_q;
    pop_d        = '0;
    push_d       = '0;
    d_push_d     = '0;
    drop_d       = drop_q;
    case (state_q)
      IDLE: begin
        if (|pndng) begin
          state_d      = SEND;
          last_grant_d = rr_grant;
          word_d       = src_word[rr_grant];
          pop_d        = DEVICES'(1) << rr_grant;
        end
      end
      SEND: begin
        state_d = IDLE;
        push_d  = dest_mask;
        if (|dest_mask) d_push_d = word_q;
        else if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(DEVICES - 1);
      word_q       <= '0;
      pop_q        <= '0;
      push_q       <= '0;
      d_push_q     <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      word_q       <= word_d;
      pop_q        <= pop_d;
      push_q       <= push_d;
      d_push_q     <= d_push_d;
      drop_q       <= drop_d;
    end
  end

  assign pop      = pop_q;
  assign push     = push_q;
  assign d_push   = d_push_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter: FIFO queues per device and a transaction-level reference model.
module tb_bus_arbiter;
  localparam int D = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [D-1:0]   pndng;
  logic [D*W-1:0] d_pop;
  logic [D-1:0]   pop;
  logic [W-1:0]   d_push;
  logic [D-1:0]   push;
  logic [7:0]     drop_cnt;

  bus_arbiter #(.DEVICES(D), .WIDTH(W), .BROADCAST(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .d_pop(d_pop),
    .pop(pop), .d_push(d_push), .push(push), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  logic [W-1:0] fifo_q [D][$];
  int checks = 0;
  int failures = 0;

  // Reference model: at most one packet in flight; it is delivered on the edge after its grant.
  int           m_last;
  bit           pend_valid;
  int           pend_src;
  logic [D-1:0] pend_mask;
  logic [W-1:0] pend_word;
  logic [D-1:0] e_pop, e_push;
  logic [W-1:0] e_dpush;
  int           e_cnt;
  int           cyc = 0;
  int           grant_log[$];
  int           grant_edge[$];
  logic [D-1:0] obs_push_or;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [D-1:0] exp_mask(logic [W-1:0] w, int g);
    int dest;
    dest = int'(w[W-1:W-8]);
`ifdef BUS_ARBITER_BROADCAST_EN
    if (dest == 255) return {D{1'b1}} & ~(D'(1) << g);
`endif
    if (dest < D && dest != g) return D'(1) << dest;
    return '0;
  endfunction

  task automatic drive();
    for (int i = 0; i < D; i++) begin
      pndng[i] = (fifo_q[i].size() != 0);
      d_pop[i*W +: W] = (fifo_q[i].size() != 0) ? fifo_q[i][0] : '0;
    end
  endtask

  task automatic add(int dev, logic [W-1:0] w);
    fifo_q[dev].push_back(w);
    drive();
  endtask

  task automatic model_edge();
    int g;
    cyc++;
    e_pop = '0; e_push = '0; e_dpush = '0;
    if (reset) begin
      pend_valid = 0;
      e_cnt = 0;
      m_last = D - 1;
    end else if (pend_valid) begin
      e_push = pend_mask;
      e_dpush = (pend_mask != 0) ? pend_word : '0;
      if (pend_mask == 0 && e_cnt < 255) e_cnt++;
      pend_valid = 0;
      $display("txn src=%0d word=%h mask=%b %s", pend_src, pend_word, pend_mask,
               (pend_mask == 0) ? "dropped" : "delivered");
    end else begin
      g = -1;
      for (int k = 1; k <= D; k++) begin
        if (g < 0 && fifo_q[(m_last + k) % D].size() != 0) g = (m_last + k) % D;
      end
      if (g >= 0) begin
        m_last = g;
        e_pop = D'(1) << g;
        pend_word = fifo_q[g][0];
        pend_mask = exp_mask(pend_word, g);
        pend_src = g;
        pend_valid = 1;
        grant_log.push_back(g);
        grant_edge.push_back(cyc);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("pop", pop, e_pop);
    check_eq("push", push, e_push);
    check_eq("d_push", d_push, e_dpush);
    check_eq("drop_cnt", drop_cnt, e_cnt);
    obs_push_or |= push;
    for (int i = 0; i < D; i++) if (e_pop[i]) void'(fifo_q[i].pop_front());
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    grant_log.delete();
    grant_edge.delete();
    obs_push_or = '0;
  endtask

  function automatic bit busy();
    bit b;
    b = pend_valid;
    for (int i = 0; i < D; i++) if (fifo_q[i].size() != 0) b = 1;
    return b;
  endfunction

  task automatic drain(int limit);
    int n;
    n = 0;
    while (busy() && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) check_eq("drain_timeout", 32'd1, 32'd0);
    step();
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    int n;
    int pick;
    logic [7:0] dst;
    reset = 1'b1;
    obs_push_or = '0;
    drive();
    step();
    step();
    check_eq("rst_drop_cnt", drop_cnt, 32'd0);
    reset = 1'b0;

    // Single unicast from device 0 to device 2.
    add(0, 16'h02AB);
    repeat (4) step();
    check_eq("single_push_seen", obs_push_or, 32'b0100);

    // All devices pending: strict rotation and one packet every two cycles.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < D; i++) add(i, {8'((i + 1) % D), 8'(r * 16 + i)});
    drain(100);
    check_eq("rr_count", grant_log.size() >= 5, 32'd1);
    for (int k = 0; k < 5 && k < grant_log.size(); k++) begin
      check_eq("rr_order", grant_log[k], exp_order[k]);
      if (k > 0) check_eq("rr_spacing", grant_edge[k] - grant_edge[k-1], 32'd2);
    end

    // Self-addressed and out-of-range packets are popped and counted.
    do_reset();
    add(1, 16'h01CD);
    add(1, 16'h07CD);
    drain(50);
    check_eq("self_invalid_drop", drop_cnt, 32'd2);
    check_eq("self_invalid_push", obs_push_or, 32'd0);

    // Broadcast destination.
    do_reset();
    add(2, 16'hFF55);
    drain(50);
`ifdef BUS_ARBITER_BROADCAST_EN
    check_eq("bcast_push", obs_push_or, 32'b1011);
    check_eq("bcast_drop", drop_cnt, 32'd0);
`else
    check_eq("bcast_push", obs_push_or, 32'd0);
    check_eq("bcast_drop", drop_cnt, 32'd1);
`endif

    // Reset landing in the SEND cycle aborts the packet.
    do_reset();
    add(1, 16'h0055);
    n = 0;
    while (e_pop == 0 && n < 10) begin
      step();
      n++;
    end
    check_eq("abort_reached_send", n < 10, 32'd1);
    do_reset();
    add(2, 16'h0011);
    add(0, 16'h0122);
    drain(50);
    check_eq("abort_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 32'd0);
    check_eq("abort_pushes", obs_push_or, 32'b0011);

    // Saturation of the drop counter.
    do_reset();
    for (int i = 0; i < 300; i++) add(0, {8'h07, 8'(i)});
    drain(700);
    check_eq("drop_saturate", drop_cnt, 32'hFF);

    // Random traffic with occasional resets.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < D; i++) begin
        if ($urandom_range(0, 3) == 0 && fifo_q[i].size() < 8) begin
          pick = $urandom_range(0, 9);
          if (pick < 4)      dst = 8'(pick);
          else if (pick < 6) dst = 8'($urandom_range(4, 7));
          else if (pick < 8) dst = 8'hFF;
          else               dst = 8'($urandom_range(0, 255));
          add(i, {dst, 8'($urandom)});
        end
      end
      if ($urandom_range(0, 149) == 0) reset = 1'b1;
      step();
      reset = 1'b0;
    end
    drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The module SHALL have parameter DEVICES, default 4: number of attached device FIFOs, 2..16.
REQ-002 The module SHALL have parameter WIDTH, default 16: packet width in bits, at least 9.
REQ-003 The module SHALL have parameter BROADCAST, default 8'hFF: destination ID meaning all devices.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port pndng, input, DEVICES bits: bit i high means device i's transmit FIFO is non-empty.
REQ-007 The module SHALL have port d_pop, input, DEVICES*WIDTH bits: head word of FIFO i at bits [i*WIDTH +: WIDTH], first-word-fall-through.
REQ-008 The module SHALL have port pop, output, DEVICES bits: one-hot pop strobe to the source FIFOs.
REQ-009 The module SHALL have port d_push, output, WIDTH bits: shared bus data to the receive FIFOs.
REQ-010 The module SHALL have port push, output, DEVICES bits: push strobe per destination receive FIFO.
REQ-011 The module SHALL have port drop_cnt, output, 8 bits: saturating count of discarded packets.

Function
REQ-012 The destination ID SHALL be d_pop word bits [WIDTH-1:WIDTH-8]; the remaining bits are payload and SHALL pass through unmodified.
REQ-013 The FSM SHALL have exactly two states, IDLE and SEND.
REQ-014 IDLE with pndng==0: SHALL stay in IDLE; pop and push SHALL be 0.
REQ-015 IDLE with pndng!=0: SHALL grant index g, the first set bit searching upward circularly from last_grant+1.
REQ-016 On that IDLE edge the block SHALL latch g and the word at slice g, register pop to one-hot g, and go to SEND.
REQ-017 pop[g] SHALL therefore be high for exactly one cycle, the cycle in SEND.
REQ-018 In SEND the block SHALL drive d_push with the latched word and push with the destination mask, both registered.
REQ-019 Push SHALL be valid in the cycle after SEND; the FSM SHALL return to IDLE, giving at most one packet per 2 cycles.
REQ-020 push and d_push SHALL be 0 in every cycle not directly following SEND.
REQ-021 Destination mask, unicast: one-hot bit dest when dest<DEVICES and dest!=g.
REQ-022 Destination mask, drop case: all zero when dest>=DEVICES (and not an enabled broadcast) or dest==g.
REQ-023 On a drop the source word SHALL still be popped, and drop_cnt SHALL increment, saturating at 255.
REQ-024 last_grant SHALL update to g on every grant, so a device never wins twice in a row while another device is pending.
REQ-025 A pndng bit falling while the FSM is in SEND SHALL NOT affect the transaction in flight.
REQ-026 Any device SHALL be granted within DEVICES grants of asserting pndng.

Reset
REQ-027 While reset is high at a rising clk: FSM SHALL go to IDLE, pop=0, push=0, d_push=0, drop_cnt=0, last_grant=DEVICES-1 (device 0 wins first).
REQ-028 Reset asserted in SEND SHALL abort the transfer: no push SHALL be issued, and the already-popped word is lost.
REQ-029 After reset deasserts, the first grant SHALL be no earlier than the following edge.

Configuration
REQ-030 With macro BUS_ARBITER_BROADCAST_EN defined, dest==BROADCAST SHALL push all devices except g, with identical d_push.
REQ-031 Without BUS_ARBITER_BROADCAST_EN, dest==BROADCAST SHALL be treated as invalid: dropped and counted.

Verification
REQ-032 Reset, then pndng=4'b0001, d_pop[0]=16'h02AB -> pop=4'b0001 for 1 cycle, next cycle push=4'b0100 with d_push=16'h02AB, drop_cnt=0.
REQ-033 pndng=4'b1111 held, every dest valid -> grant order 0,1,2,3,0 and one push every 2 cycles.
REQ-034 Device 1 sends 16'h01CD (self) and then 16'h07CD (invalid) -> both popped, push stays 0, drop_cnt=2.
REQ-035 Device 2 sends 16'hFF55 -> with BUS_ARBITER_BROADCAST_EN push=4'b1011 and d_push=16'hFF55; without it push=0 and drop_cnt=1.
REQ-036 Reset asserted in SEND -> no push follows, all outputs 0, and the next grant goes to device 0.
REQ-037 300 invalid packets -> drop_cnt saturates at 8'hFF.
